// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: Moore sequencer driving the AES-128 inverse-cipher datapath.
// It launches key expansion, loads the ciphertext and walks the state through
// the initial key add, nine full inverse rounds and the final round. It then
// pulses the result write and holds DONE until software releases START.
module aes_dec_ctrl #(
    parameter int KEYEXP_CYCLES = 10,
    parameter int SUB_CYCLES    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AES_START,
    output logic       keyexp_start,
    output logic       st_load_msg,
    output logic       st_load,
    output logic [2:0] op_sel,
    output logic [3:0] rk_sel,
    output logic [1:0] col_sel,
    output logic       res_we,
    output logic       AES_DONE,
    output logic       busy
);

    localparam logic [2:0] OP_NONE     = 3'd0;
    localparam logic [2:0] OP_ADDKEY   = 3'd1;
    localparam logic [2:0] OP_INVSHIFT = 3'd2;
    localparam logic [2:0] OP_INVSUB   = 3'd3;
    localparam logic [2:0] OP_INVMIX   = 3'd4;

    // One shared wait counter covers both the key-expansion delay and the
    // InvSubBytes latency. It also flags the first DONE cycle.
    localparam int MAX_WAIT = (KEYEXP_CYCLES > SUB_CYCLES) ? KEYEXP_CYCLES : SUB_CYCLES;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] KEYEXP_LAST = CNT_W'(KEYEXP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SUB_LAST    = CNT_W'(SUB_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_KEYEXP,
        S_LOAD,
        S_ARK_INIT,
        S_ISR,
        S_ISB,
        S_ARK,
        S_IMC,
        S_F_ISR,
        S_F_ISB,
        S_F_ARK,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [3:0]       round, round_next;
    logic [1:0]       col, col_next;
    logic [CNT_W-1:0] wait_cnt, wait_next;

    // State, round, column and wait registers; a synchronous reset returns everything to IDLE with zero counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            round    <= 4'd0;
            col      <= 2'd0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            round    <= round_next;
            col      <= col_next;
            wait_cnt <= wait_next;
        end
    end

    // Next-state and counter update: sequence through the key schedule, the rounds and the final round, then hold in DONE.
    always_comb begin
        state_next = state;
        round_next = round;
        col_next   = col;
        wait_next  = wait_cnt;
        case (state)
            S_IDLE: begin
                if (AES_START) begin
                    state_next = S_KEYEXP;
                    wait_next  = '0;
                end
            end
            S_KEYEXP: begin
                if (wait_cnt == KEYEXP_LAST) begin
                    state_next = S_LOAD;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            S_LOAD: begin
                state_next = S_ARK_INIT;
            end
            S_ARK_INIT: begin
                round_next = 4'd9;
                state_next = S_ISR;
            end
            S_ISR: begin
                state_next = S_ISB;
                wait_next  = '0;
            end
            S_ISB: begin
                if (wait_cnt == SUB_LAST) begin
                    state_next = S_ARK;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            S_ARK: begin
                state_next = S_IMC;
                col_next   = 2'd0;
            end
            S_IMC: begin
                col_next = col + 2'd1;
                if (col == 2'd3) begin
                    if (round == 4'd1) begin
                        state_next = S_F_ISR;
                    end else begin
                        round_next = round - 4'd1;
                        state_next = S_ISR;
                    end
                end
            end
            S_F_ISR: begin
                state_next = S_F_ISB;
                wait_next  = '0;
            end
            S_F_ISB: begin
                if (wait_cnt == SUB_LAST) begin
                    state_next = S_F_ARK;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            S_F_ARK: begin
                state_next = S_DONE;
                wait_next  = '0;
            end
            S_DONE: begin
                wait_next = CNT_W'(1);
                if (!AES_START) begin
                    state_next = S_IDLE;
                    wait_next  = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state and counters only; rk_sel keeps the last applied round key between key adds.
    always_comb begin
        keyexp_start = 1'b0;
        st_load_msg  = 1'b0;
        st_load      = 1'b0;
        op_sel       = OP_NONE;
        rk_sel       = 4'd0;
        col_sel      = col;
        res_we       = 1'b0;
        AES_DONE     = 1'b0;
        busy         = (state != S_IDLE) && (state != S_DONE);
        case (state)
            S_KEYEXP: begin
                keyexp_start = (wait_cnt == '0);
            end
            S_LOAD: begin
                st_load_msg = 1'b1;
            end
            S_ARK_INIT: begin
                op_sel  = OP_ADDKEY;
                rk_sel  = 4'd10;
                st_load = 1'b1;
            end
            S_ISR: begin
                op_sel  = OP_INVSHIFT;
                rk_sel  = round + 4'd1;
                st_load = 1'b1;
            end
            S_ISB: begin
                op_sel  = OP_INVSUB;
                rk_sel  = round + 4'd1;
                st_load = (wait_cnt == SUB_LAST);
            end
            S_ARK: begin
                op_sel  = OP_ADDKEY;
                rk_sel  = round;
                st_load = 1'b1;
            end
            S_IMC: begin
                op_sel  = OP_INVMIX;
                rk_sel  = round;
                st_load = 1'b1;
            end
            S_F_ISR: begin
                op_sel  = OP_INVSHIFT;
                rk_sel  = round;
                st_load = 1'b1;
            end
            S_F_ISB: begin
                op_sel  = OP_INVSUB;
                rk_sel  = round;
                st_load = (wait_cnt == SUB_LAST);
            end
            S_F_ARK: begin
                op_sel  = OP_ADDKEY;
                rk_sel  = 4'd0;
                st_load = 1'b1;
            end
            S_DONE: begin
                AES_DONE = 1'b1;
                res_we   = (wait_cnt == '0);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb_aes_dec_ctrl: drives aes_dec_ctrl through full decryptions with a
// behavioural AES inverse datapath attached, and scores the control stream
// against queued expectations (round-key order, column order, result, timing).
module tb_aes_dec_ctrl;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       AES_START;
    logic       keyexp_start, st_load_msg, st_load, res_we, AES_DONE, busy;
    logic [2:0] op_sel;
    logic [3:0] rk_sel;
    logic [1:0] col_sel;

    logic       start_f;
    logic       keyexp_start_f, st_load_msg_f, st_load_f, res_we_f, done_f, busy_f;
    logic [2:0] op_sel_f;
    logic [3:0] rk_sel_f;
    logic [1:0] col_sel_f;

    typedef struct {
        logic [127:0] pt;
        int           done_cyc;
    } res_t;

    int           tests_run = 0;
    int           tests_failed = 0;
    int           cyc = 0;
    logic [7:0]   sbox_t[256];
    logic [7:0]   inv_t[256];
    logic [127:0] rk_tab[11];
    logic [127:0] model;
    int           rk_q[$];
    int           col_q[$];
    res_t         res_q[$];
    int           kx_cycle, kx_count, msg_cycle, load_cnt, overlap_cnt;
    int           first_done, done_cycles, res_we_cnt, last_col_cyc;

    always #5 CLK = ~CLK;

    aes_dec_ctrl dut (
        .CLK(CLK), .RESET(RESET), .AES_START(AES_START),
        .keyexp_start(keyexp_start), .st_load_msg(st_load_msg), .st_load(st_load),
        .op_sel(op_sel), .rk_sel(rk_sel), .col_sel(col_sel),
        .res_we(res_we), .AES_DONE(AES_DONE), .busy(busy)
    );

    aes_dec_ctrl #(.KEYEXP_CYCLES(1), .SUB_CYCLES(1)) dut_fast (
        .CLK(CLK), .RESET(RESET), .AES_START(start_f),
        .keyexp_start(keyexp_start_f), .st_load_msg(st_load_msg_f), .st_load(st_load_f),
        .op_sel(op_sel_f), .rk_sel(rk_sel_f), .col_sel(col_sel_f),
        .res_we(res_we_f), .AES_DONE(done_f), .busy(busy_f)
    );

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    function automatic void build_tables();
        logic [7:0]  inv, s, rcon;
        logic [31:0] w[44];
        logic [31:0] temp;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_t[x] = s;
            inv_t[s]  = 8'(x);
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_t[temp[31:24]], sbox_t[temp[23:16]], sbox_t[temp[15:8]], sbox_t[temp[7:0]]};
                temp = temp ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_t[s[127-8*k -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s, input int c);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o  = s;
        a0 = s[127-8*(4*c)   -: 8];
        a1 = s[127-8*(4*c+1) -: 8];
        a2 = s[127-8*(4*c+2) -: 8];
        a3 = s[127-8*(4*c+3) -: 8];
        o[127-8*(4*c)   -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
        o[127-8*(4*c+1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
        o[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
        o[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        return o;
    endfunction

    // ---------------- checking and scoreboard ----------------
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observes one cycle of the main DUT, advances the golden datapath and pops expectations.
    task automatic monitor_cycle();
        res_t e;
        int   exp_v;
        if (st_load && st_load_msg) overlap_cnt++;
        if (keyexp_start) begin
            kx_count++;
            if (kx_cycle < 0) kx_cycle = cyc;
        end
        if (res_we) begin
            res_we_cnt++;
            if (res_q.size() == 0) checkOutput("unexpected res_we", 128'(res_we), 128'(0));
            else begin
                e = res_q.pop_front();
                checkOutput("state at res_we", model, e.pt);
                checkOutput("res_we cycle", 128'(cyc), 128'(e.done_cyc));
            end
        end
        if (AES_DONE) begin
            done_cycles++;
            if (first_done < 0) begin
                first_done = cyc;
                checkOutput("busy at first done", 128'(busy), 128'(0));
            end
        end
        if (st_load_msg) begin
            msg_cycle = cyc;
            model     = CT;
        end
        if (st_load) begin
            load_cnt++;
            case (op_sel)
                3'd1: begin
                    if (rk_q.size() == 0) checkOutput("extra addkey", 128'(rk_sel), 128'(15));
                    else begin
                        exp_v = rk_q.pop_front();
                        checkOutput("rk_sel", 128'(rk_sel), 128'(exp_v));
                    end
                    if (rk_sel <= 4'd10) model = model ^ rk_tab[rk_sel];
                end
                3'd2: model = inv_shift(model);
                3'd3: model = inv_sub(model);
                3'd4: begin
                    if (col_q.size() == 0) checkOutput("extra invmix", 128'(col_sel), 128'(4));
                    else begin
                        exp_v = col_q.pop_front();
                        checkOutput("col_sel", 128'(col_sel), 128'(exp_v));
                        if (exp_v != 0) checkOutput("invmix consecutive", 128'(cyc), 128'(last_col_cyc + 1));
                    end
                    last_col_cyc = cyc;
                    model = inv_mix(model, int'(col_sel));
                end
                default: checkOutput("st_load with bad op_sel", 128'(op_sel), 128'(1));
            endcase
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        monitor_cycle();
    endtask

    // Raises START (next edge is edge 0) and queues everything the run must produce.
    task automatic applyStimulus();
        rk_q.delete(); col_q.delete(); res_q.delete();
        for (int r = 10; r >= 0; r--) rk_q.push_back(r);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 4; c++) col_q.push_back(c);
        res_q.push_back('{pt: PT, done_cyc: 89});
        kx_cycle = -1; kx_count = 0; msg_cycle = -1; load_cnt = 0; overlap_cnt = 0;
        first_done = -1; done_cycles = 0; res_we_cnt = 0; last_col_cyc = -10;
        model = '0;
        AES_START = 1'b1;
        cyc = 0;
    endtask

    task automatic run_until_done();
        while (first_done < 0 && cyc < 200) tick();
        if (first_done < 0) checkOutput("done timeout", 128'(0), 128'(1));
    endtask

    task automatic end_of_run_checks();
        checkOutput("keyexp_start cycle", 128'(kx_cycle), 128'(1));
        checkOutput("st_load_msg cycle", 128'(msg_cycle), 128'(11));
        checkOutput("first done cycle", 128'(first_done), 128'(89));
        checkOutput("st_load pulses", 128'(load_cnt), 128'(67));
        checkOutput("load overlap", 128'(overlap_cnt), 128'(0));
        checkOutput("rk queue drained", 128'(rk_q.size()), 128'(0));
        checkOutput("col queue drained", 128'(col_q.size()), 128'(0));
        checkOutput("result queue drained", 128'(res_q.size()), 128'(0));
    endtask

    // Directed sequence: reset, held-START run, re-run, mid-run reset, fast variant with pulsed START.
    initial begin
        int f_done, f_cnt, f_res;
        build_tables();
        RESET = 1'b1; AES_START = 1'b0; start_f = 1'b0;
        tick(); tick();
        checkOutput("reset outputs", 128'({keyexp_start, st_load_msg, st_load, op_sel, rk_sel, col_sel, res_we, AES_DONE, busy}), 128'(0));
        checkOutput("reset outputs fast", 128'({keyexp_start_f, st_load_msg_f, st_load_f, op_sel_f, rk_sel_f, col_sel_f, res_we_f, done_f, busy_f}), 128'(0));
        RESET = 1'b0;
        tick();

        applyStimulus();
        run_until_done();
        end_of_run_checks();
        repeat (20) tick();
        checkOutput("done held cycles", 128'(done_cycles), 128'(21));
        checkOutput("res_we pulses", 128'(res_we_cnt), 128'(1));
        checkOutput("no restart while held", 128'(kx_count), 128'(1));
        AES_START = 1'b0;
        tick();
        checkOutput("done after release", 128'(AES_DONE), 128'(0));
        checkOutput("busy after release", 128'(busy), 128'(0));
        tick();

        applyStimulus();
        run_until_done();
        end_of_run_checks();
        AES_START = 1'b0;
        tick(); tick();

        applyStimulus();
        while (cyc < 40) tick();
        RESET = 1'b1;
        tick();
        checkOutput("outputs after mid-run reset", 128'({keyexp_start, st_load_msg, st_load, op_sel, rk_sel, col_sel, res_we, AES_DONE, busy}), 128'(0));
        RESET = 1'b0;
        applyStimulus();
        run_until_done();
        end_of_run_checks();
        AES_START = 1'b0;
        tick(); tick();

        f_done = -1; f_cnt = 0; f_res = -1;
        start_f = 1'b1;
        cyc = 0;
        tick();
        start_f = 1'b0;
        while (cyc < 200 && (f_done < 0 || cyc < f_done + 3)) begin
            tick();
            if (done_f) begin
                f_cnt++;
                if (f_done < 0) f_done = cyc;
            end
            if (res_we_f && f_res < 0) f_res = cyc;
        end
        checkOutput("fast done cycle", 128'(f_done), 128'(70));
        checkOutput("fast res_we cycle", 128'(f_res), 128'(70));
        checkOutput("fast done length", 128'(f_cnt), 128'(1));
        checkOutput("fast idle after", 128'({done_f, busy_f}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, tests_failed %0d", tests_failed);
        $fatal(1, "[TB] watchdog");
    end

endmodule
